// File: rtl/sie_rx_ctrl_if.sv
// Receive-side bus of the serial interface engine: line bits in, SIPO
// control out/parallel byte in, framed byte stream out.
interface sie_rx_ctrl_if;
    logic       bit_valid;
    logic       bit_in;
    logic       se0;
    logic       sipo_ser;
    logic       sipo_shift_en;
    logic       sipo_clr;
    logic [7:0] sipo_par;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_sop;
    logic       rx_eop;
    logic       rx_err;
    logic [1:0] rx_err_code;
    logic       busy;

    // Sequencer view
    modport slave (
        input  bit_valid, bit_in, se0, sipo_par,
        output sipo_ser, sipo_shift_en, sipo_clr,
        output rx_data, rx_valid, rx_sop, rx_eop, rx_err, rx_err_code, busy
    );

    // Line / SIPO / protocol-layer view
    modport master (
        output bit_valid, bit_in, se0, sipo_par,
        input  sipo_ser, sipo_shift_en, sipo_clr,
        input  rx_data, rx_valid, rx_sop, rx_eop, rx_err, rx_err_code, busy
    );
endinterface

// File: rtl/sie_rx_ctrl.sv
// USB receive sequencer: SYNC hunt, bit unstuffing, SIPO drive and byte
// framing with start/end/error indications.
module sie_rx_ctrl #(
    parameter logic [7:0] SYNC_PATTERN = 8'h80,
    parameter int         STUFF_LEN    = 6,
    parameter int         MAX_BYTES    = 67
) (
    input  logic      clk,
    input  logic      rst,
    sie_rx_ctrl_if.slave bus
);
    localparam logic [2:0] STUFF_N = 3'(STUFF_LEN);
    localparam logic [6:0] MAX_N   = 7'(MAX_BYTES);

    typedef enum logic [2:0] {IDLE, HUNT, DATA, EOP, ERR} state_t;

    state_t     state, state_nx;
    logic [7:0] hunt, hunt_nx, hunt_sh;
    logic [2:0] bit_cnt, bit_nx;
    logic [6:0] byte_cnt, byte_nx;
    logic [2:0] ones_cnt, ones_nx;
    logic       shift_req, clr_req, eop_req, err_req, done_req, sop_req;
    logic [1:0] code_nx;

    // Byte completion pipeline: [1] shift in flight, [2] SIPO byte ready
    logic [2:1] vld_pipe, sop_pipe;
    logic       eop_p1;

    logic       sipo_ser_q, sipo_shift_q, sipo_clr_q;
    logic [7:0] rx_data_q;
    logic       rx_valid_q, rx_sop_q, rx_eop_q, rx_err_q;
    logic [1:0] rx_code_q;

    // Next-state and per-bit control decisions
    always_comb begin
        state_nx  = state;
        hunt_nx   = hunt;
        hunt_sh   = {bus.bit_in, hunt[7:1]};
        bit_nx    = bit_cnt;
        byte_nx   = byte_cnt;
        ones_nx   = ones_cnt;
        shift_req = 1'b0;
        clr_req   = 1'b0;
        eop_req   = 1'b0;
        err_req   = 1'b0;
        code_nx   = 2'b00;
        done_req  = 1'b0;
        sop_req   = 1'b0;
        case (state)
            IDLE: if (bus.bit_valid && !bus.se0 && !bus.bit_in) begin
                hunt_nx  = {bus.bit_in, 7'b0};
                state_nx = HUNT;
            end
            HUNT: if (bus.bit_valid) begin
                if (bus.se0) begin
                    state_nx = IDLE;
                end else begin
                    hunt_nx = hunt_sh;
                    if (hunt_sh == SYNC_PATTERN) begin
                        clr_req  = 1'b1;
                        bit_nx   = 3'd0;
                        byte_nx  = 7'd0;
                        // trailing 1 of SYNC counts toward the stuffing run
                        ones_nx  = 3'd1;
                        state_nx = DATA;
                    end
                end
            end
            DATA: if (bus.bit_valid) begin
                if (bus.se0) begin
                    state_nx = EOP;
                    if (bit_cnt == 3'd0 && byte_cnt != 7'd0) begin
                        eop_req = 1'b1;
                    end else begin
                        err_req = 1'b1;
                        code_nx = 2'b10;
                    end
                end else if (ones_cnt == STUFF_N) begin
                    if (!bus.bit_in) begin
                        ones_nx = 3'd0;
                    end else begin
                        err_req  = 1'b1;
                        code_nx  = 2'b01;
                        state_nx = ERR;
                    end
                end else begin
                    shift_req = 1'b1;
                    bit_nx    = bit_cnt + 3'd1;
                    ones_nx   = bus.bit_in ? ones_cnt + 3'd1 : 3'd0;
                    if (bit_cnt == 3'd7) begin
                        if (byte_cnt == MAX_N) begin
                            err_req  = 1'b1;
                            code_nx  = 2'b11;
                            state_nx = ERR;
                        end else begin
                            done_req = 1'b1;
                            sop_req  = (byte_cnt == 7'd0);
                            byte_nx  = byte_cnt + 7'd1;
                        end
                    end
                end
            end
            EOP: if (bus.bit_valid && !bus.se0) state_nx = IDLE;
            ERR: if (bus.bit_valid && bus.se0) state_nx = EOP;
            default: state_nx = IDLE;
        endcase
    end

    // State and bit/byte/stuffing counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            hunt     <= 8'h00;
            bit_cnt  <= 3'd0;
            byte_cnt <= 7'd0;
            ones_cnt <= 3'd0;
        end else begin
            state    <= state_nx;
            hunt     <= hunt_nx;
            bit_cnt  <= bit_nx;
            byte_cnt <= byte_nx;
            ones_cnt <= ones_nx;
        end
    end

    // SIPO drive: one-cycle shift or clear strobe after the deciding bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sipo_ser_q   <= 1'b0;
            sipo_shift_q <= 1'b0;
            sipo_clr_q   <= 1'b0;
        end else begin
            sipo_shift_q <= shift_req;
            sipo_clr_q   <= clr_req;
            if (shift_req) sipo_ser_q <= bus.bit_in;
        end
    end

    // Byte capture, end-of-packet delay and error reporting
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe   <= '0;
            sop_pipe   <= '0;
            eop_p1     <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            rx_sop_q   <= 1'b0;
            rx_eop_q   <= 1'b0;
            rx_err_q   <= 1'b0;
            rx_code_q  <= 2'b00;
        end else begin
            vld_pipe   <= {vld_pipe[1], done_req};
            sop_pipe   <= {sop_pipe[1], sop_req};
            eop_p1     <= eop_req;
            rx_eop_q   <= eop_p1;
            rx_err_q   <= err_req;
            rx_valid_q <= vld_pipe[2];
            rx_sop_q   <= vld_pipe[2] & sop_pipe[2];
            if (vld_pipe[2]) rx_data_q <= bus.sipo_par;
            if (err_req)     rx_code_q <= code_nx;
        end
    end

    assign bus.sipo_ser      = sipo_ser_q;
    assign bus.sipo_shift_en = sipo_shift_q;
    assign bus.sipo_clr      = sipo_clr_q;
    assign bus.rx_data       = rx_data_q;
    assign bus.rx_valid      = rx_valid_q;
    assign bus.rx_sop        = rx_sop_q;
    assign bus.rx_eop        = rx_eop_q;
    assign bus.rx_err        = rx_err_q;
    assign bus.rx_err_code   = rx_code_q;
    assign bus.busy          = (state != IDLE);
endmodule

// File: tb/tb_sie_rx_ctrl.sv
// Self-checking bench for sie_rx_ctrl: packets are encoded (SYNC + LSB-first
// bytes + bit stuffing) by a reference encoder and the framed output stream
// is compared against the original bytes.
module tb_sie_rx_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;

    sie_rx_ctrl_if bus();

    sie_rx_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Behavioural SIPO: LSB-first shift register filling from the MSB
    logic [7:0] sipo_q = 8'h00;
    always @(posedge clk) begin
        if (bus.sipo_clr)           sipo_q <= 8'h00;
        else if (bus.sipo_shift_en) sipo_q <= {bus.sipo_ser, sipo_q[7:1]};
    end
    assign bus.sipo_par = sipo_q;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor
    logic [8:0] rx_q[$];
    int rxv_cyc[$];
    int bv_cyc[$];
    int eop_tot = 0, err_tot = 0, shift_tot = 0, inv_bad = 0, eop_cyc = 0;
    always @(negedge clk) begin
        if (bus.bit_valid) bv_cyc.push_back(cyc);
        if (bus.rx_valid) begin
            rx_q.push_back({bus.rx_sop, bus.rx_data});
            rxv_cyc.push_back(cyc);
        end
        if (bus.rx_eop) begin
            eop_tot <= eop_tot + 1;
            eop_cyc <= cyc;
        end
        if (bus.rx_err)        err_tot   <= err_tot + 1;
        if (bus.sipo_shift_en) shift_tot <= shift_tot + 1;
        if ((bus.rx_eop && bus.rx_err) || (bus.sipo_clr && bus.sipo_shift_en))
            inv_bad <= inv_bad + 1;
    end

    int n_chk = 0, n_fail = 0;
    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference encoder
    logic [7:0] pkt[$];
    logic       stream[$];
    int         end_idx[$];
    task automatic build();
        int ones;
        stream.delete();
        end_idx.delete();
        for (int i = 0; i < 7; i++) stream.push_back(1'b0);
        stream.push_back(1'b1);
        ones = 1;
        foreach (pkt[k]) begin
            for (int i = 0; i < 8; i++) begin
                logic b;
                b = pkt[k][i];
                stream.push_back(b);
                ones = b ? ones + 1 : 0;
                if (i == 7) end_idx.push_back(stream.size() - 1);
                if (ones == 6) begin
                    stream.push_back(1'b0);
                    ones = 0;
                end
            end
        end
    endtask

    task automatic send_bit(input logic b, input logic s);
        @(posedge clk); #1;
        bus.bit_in = b; bus.se0 = s; bus.bit_valid = 1'b1;
        @(posedge clk); #1;
        bus.bit_valid = 1'b0;
        repeat ($urandom_range(2, 4)) @(posedge clk);
    endtask

    task automatic send_stream();
        foreach (stream[i]) send_bit(stream[i], 1'b0);
    endtask

    int rb, eb, erb, sb, bb;
    task automatic snap();
        rb = rx_q.size(); eb = eop_tot; erb = err_tot; sb = shift_tot; bb = bv_cyc.size();
    endtask

    function automatic int outs_or();
        return int'({bus.sipo_ser, bus.sipo_shift_en, bus.sipo_clr, bus.rx_data,
                     bus.rx_valid, bus.rx_sop, bus.rx_eop, bus.rx_err,
                     bus.rx_err_code, bus.busy});
    endfunction

    // Clean packet: bytes back in order, sop on first, one eop, no error
    task automatic run_good(input string tag);
        snap();
        build();
        send_stream();
        chk({tag, " busy mid"}, int'(bus.busy), 1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        chk({tag, " byte count"}, rx_q.size() - rb, pkt.size());
        foreach (pkt[k]) begin
            if (rb + k < rx_q.size())
                chk($sformatf("%s byte%0d", tag, k), int'(rx_q[rb + k]),
                    int'({(k == 0), pkt[k]}));
        end
        chk({tag, " eop"}, eop_tot - eb, 1);
        chk({tag, " err"}, err_tot - erb, 0);
        chk({tag, " shifts"}, shift_tot - sb, 8 * pkt.size());
        chk({tag, " busy end"}, int'(bus.busy), 0);
        if (rx_q.size() > rb)
            chk({tag, " byte latency"}, rxv_cyc[rb] - bv_cyc[bb + end_idx[0]], 3);
        chk({tag, " eop latency"}, eop_cyc - bv_cyc[bb + stream.size()], 2);
    endtask

    initial begin
        bus.bit_valid = 1'b0; bus.bit_in = 1'b0; bus.se0 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs", outs_or(), 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // Two-byte packet
        pkt = '{8'hC3, 8'h5A};
        run_good("t1");

        // Stuffed 0xFF followed by 0x00
        pkt = '{8'hFF, 8'h00};
        run_good("t2");

        // Stuff error: a 1 where a stuffed 0 is due
        snap();
        pkt.delete();
        build();
        repeat (7) stream.push_back(1'b1);
        stream.push_back(1'b0); stream.push_back(1'b1); stream.push_back(1'b0);
        send_stream();
        chk("t3 busy in err", int'(bus.busy), 1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        chk("t3 err", err_tot - erb, 1);
        chk("t3 code", int'(bus.rx_err_code), 1);
        chk("t3 eop", eop_tot - eb, 0);
        chk("t3 bytes", rx_q.size() - rb, 0);
        chk("t3 busy end", int'(bus.busy), 0);

        // Framing error: one byte then 3 stray bits
        snap();
        pkt = '{8'($urandom)};
        build();
        stream.push_back(1'b0); stream.push_back(1'b1); stream.push_back(1'b0);
        send_stream();
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        chk("t4 bytes", rx_q.size() - rb, 1);
        if (rx_q.size() > rb) chk("t4 byte", int'(rx_q[rb]), int'({1'b1, pkt[0]}));
        chk("t4 err", err_tot - erb, 1);
        chk("t4 code", int'(bus.rx_err_code), 2);
        chk("t4 eop", eop_tot - eb, 0);

        // Framing error: SE0 straight after SYNC (no bytes)
        snap();
        pkt.delete();
        build();
        send_stream();
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        chk("t4b err", err_tot - erb, 1);
        chk("t4b code", int'(bus.rx_err_code), 2);
        chk("t4b eop", eop_tot - eb, 0);

        // Overflow: one byte beyond the packet limit
        snap();
        pkt.delete();
        repeat (68) pkt.push_back(8'h00);
        build();
        send_stream();
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        chk("t5 bytes", rx_q.size() - rb, 67);
        begin
            int bad = 0;
            for (int k = rb; k < rx_q.size(); k++)
                if (rx_q[k] !== {(k == rb), 8'h00}) bad++;
            chk("t5 byte stream", bad, 0);
        end
        chk("t5 err", err_tot - erb, 1);
        chk("t5 code", int'(bus.rx_err_code), 3);
        chk("t5 eop", eop_tot - eb, 0);
        chk("t5 busy end", int'(bus.busy), 0);

        // Reset mid-DATA, then a clean packet
        pkt.delete();
        build();
        repeat (4) stream.push_back(1'b0);
        send_stream();
        chk("t6 busy pre-reset", int'(bus.busy), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("t6 outputs in reset", outs_or(), 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        pkt = '{8'h81};
        run_good("t6");

        // Random packets, biased toward 0xFF to exercise stuffing
        for (int p = 0; p < 6; p++) begin
            pkt.delete();
            repeat ($urandom_range(1, 6))
                pkt.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
            run_good($sformatf("rnd%0d", p));
        end

        chk("invariants", inv_bad, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sie_rx_ctrl.md
Name: sie_rx_ctrl

Overview:
Receive-side sequencer for the serial interface engine. It consumes NRZI-decoded line bits, hunts for the USB SYNC pattern, and strips stuffed bits. It drives the external sipo_block (serial bit, shift enable, clear) and frames the assembled bytes into a packet stream with start, end and error indications for the protocol layer.

Parameters:
SYNC_PATTERN, 8'h80, SYNC byte as assembled LSB-first (decoded KJKJKJKK = 0,0,0,0,0,0,0,1)
STUFF_LEN, 6, consecutive 1s after which the next bit is a stuffed 0
MAX_BYTES, 67, maximum data bytes per packet (PID + 64 payload + CRC16)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
bit_valid  input  1  one-cycle strobe per received bit time; spacing >= 4 clk cycles
bit_in  input  1  NRZI-decoded bit, qualified by bit_valid
se0  input  1  line SE0 sample, qualified by bit_valid
sipo_ser  output  1  serial bit to the SIPO
sipo_shift_en  output  1  SIPO shift strobe
sipo_clr  output  1  SIPO clear pulse
sipo_par  input  8  SIPO parallel byte; valid 1 cycle after a shift
rx_data  output  8  received byte
rx_valid  output  1  one-cycle byte strobe
rx_sop  output  1  with rx_valid on the first byte of a packet
rx_eop  output  1  one-cycle good end-of-packet pulse
rx_err  output  1  one-cycle error pulse
rx_err_code  output  2  01 stuff error, 10 framing, 11 overflow; held until the next rx_err
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (any time, including mid-packet): state IDLE; all outputs 0; rx_data 8'h00; hunt register, bit_cnt, byte_cnt and ones_cnt cleared.
- States: IDLE, HUNT, DATA, EOP, ERR.
- IDLE: on bit_valid with se0=0 and bit_in=0, load the hunt register with that bit and go to HUNT.
- HUNT: on each bit_valid, shift bit_in into the MSB of the 8-bit hunt register (shift right).
  - se0=1: return to IDLE with no error.
  - hunt register == SYNC_PATTERN after the shift: pulse sipo_clr the next cycle; bit_cnt=0, byte_cnt=0, ones_cnt=1; go to DATA.
- DATA: on each bit_valid, in priority order:
  1. se0=1, bit_cnt==0 and byte_cnt>0: rx_eop pulses 2 cycles later; go to EOP.
  2. se0=1 otherwise: rx_err pulses with code 10; go to EOP.
  3. ones_cnt==STUFF_LEN, bit_in=0: stuffed bit dropped, no shift; ones_cnt=0.
  4. ones_cnt==STUFF_LEN, bit_in=1: rx_err pulses with code 01; go to ERR.
  5. Otherwise: a data bit.
     - Next cycle: sipo_ser=bit_in and sipo_shift_en=1 for one cycle.
     - bit_cnt increments.
     - ones_cnt increments if bit_in=1, else clears to 0.
- Byte completion:
  - On the 8th shift, bit_cnt wraps to 0.
  - 2 cycles after that shift strobe, rx_data<=sipo_par; rx_valid pulses the following cycle.
  - Latency: 8th bit_valid to rx_valid = 3 cycles.
  - rx_sop accompanies rx_valid only when byte_cnt was 0; then byte_cnt increments.
  - If byte_cnt==MAX_BYTES at completion: the byte is not delivered; rx_err pulses with code 11; go to ERR.
- EOP: wait for bit_valid with se0=0 (J), then go to IDLE.
- ERR: ignore bits until a bit_valid with se0=1 is seen; then behave as EOP.
- rx_eop and rx_err never assert in the same cycle, and at most one of them per packet.
- A pending byte delivery always completes before the rx_eop or rx_err of the same packet. This is guaranteed by the bit_valid spacing.
- sipo_clr and sipo_shift_en are never high in the same cycle.
- bit_valid arriving while a shift or capture is in flight is legal at spacing >= 4 and is processed normally.

Test Plan:
- SYNC 0,0,0,0,0,0,0,1, then bytes 0xC3 and 0x5A LSB-first, then SE0, J -> rx_valid twice with data C3 (rx_sop=1) then 5A; rx_eop once; busy falls after J; rx_err never.
- SYNC, then 0xFF with a stuffed 0 after the 6th one, then 0x00, SE0 -> bytes FF, 00; exactly 16 sipo_shift_en pulses; rx_eop.
- SYNC, six 1s, then bit_in=1 -> rx_err with code 01, no rx_eop; further bits ignored until SE0; back to IDLE after J.
- SYNC, one byte, 3 extra bits, SE0 -> one rx_valid, then rx_err with code 10, no rx_eop.
- SYNC, then 68 bytes of 0x00 -> 67 rx_valid; 68th byte suppressed; rx_err with code 11.
- Reset asserted mid-DATA after 4 bits, released, new packet with byte 0x81 -> all outputs 0 during reset; clean packet received with byte 81.
